// File: rtl/comp_flags_pipe_if.sv
// Beat interface for comp_flags_pipe: input beat, registered result flags,
// and the sticky-negative sideband (clr / sticky_ltz).
// The DUT connects through the slave modport and the producer/consumer through master.
interface comp_flags_pipe_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS-1:0]       eqz;
    logic [CHANNELS-1:0]       ltz;
    logic [CHANNELS-1:0]       gtz;
    logic [CHANNELS-1:0]       zhold;
    logic                      any_eqz;
    logic                      all_eqz;
    logic                      clr;
    logic [CHANNELS-1:0]       sticky_ltz;

    modport slave (
        input  in_valid, in_data, out_ready, clr,
        output in_ready, out_valid, eqz, ltz, gtz, zhold, any_eqz, all_eqz, sticky_ltz
    );

    modport master (
        output in_valid, in_data, out_ready, clr,
        input  in_ready, out_valid, eqz, ltz, gtz, zhold, any_eqz, all_eqz, sticky_ltz
    );
endinterface

// File: rtl/comp_flags_pipe.sv
// Registered multi-channel sign/zero flag unit with a one-deep valid/ready
// output stage and per-channel saturating zero-streak counters.
// Optional feature macro: COMP_STICKY_EN (sticky per-channel negative flag,
// cleared by clr; without it sticky_ltz is tied low and clr is ignored).
module comp_flags_pipe #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int STREAK_W = 4,
    parameter int THRESH   = 3
) (
    input logic               clk,
    input logic               rst_n,
    comp_flags_pipe_if.slave  bus
);
    localparam logic [STREAK_W-1:0] STREAK_MAX = '1;
    localparam logic [STREAK_W-1:0] THRESH_CNT = STREAK_W'(THRESH);

    logic                out_valid_q;
    logic                in_ready_w;
    logic                accept;
    logic [CHANNELS-1:0] eqz_q, ltz_q, gtz_q, zhold_q;
    logic [CHANNELS-1:0] eqz_d, ltz_d, gtz_d, zhold_d;
    logic                any_q, all_q;
    logic [STREAK_W-1:0] streak_q [CHANNELS];
    logic [STREAK_W-1:0] streak_d [CHANNELS];
    logic [WIDTH-1:0]    word;

    assign in_ready_w = !out_valid_q || bus.out_ready;
    assign accept     = bus.in_valid && in_ready_w;

    // Per-channel flags and next streak count for the beat on the input
    always_comb begin
        eqz_d   = '0;
        ltz_d   = '0;
        gtz_d   = '0;
        zhold_d = '0;
        word    = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            streak_d[c] = '0;
            word        = bus.in_data[c*WIDTH +: WIDTH];
            eqz_d[c]    = (word == '0);
            ltz_d[c]    = word[WIDTH-1];
            gtz_d[c]    = !eqz_d[c] && !ltz_d[c];
            if (eqz_d[c]) begin
                streak_d[c] = (streak_q[c] == STREAK_MAX) ? STREAK_MAX
                                                          : streak_q[c] + STREAK_W'(1);
            end
            zhold_d[c] = (streak_d[c] >= THRESH_CNT);
        end
    end

    // Output stage: load on accept, drop valid on transfer out, hold on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            eqz_q       <= '0;
            ltz_q       <= '0;
            gtz_q       <= '0;
            zhold_q     <= '0;
            any_q       <= 1'b0;
            all_q       <= 1'b0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                streak_q[c] <= '0;
            end
        end else if (accept) begin
            out_valid_q <= 1'b1;
            eqz_q       <= eqz_d;
            ltz_q       <= ltz_d;
            gtz_q       <= gtz_d;
            zhold_q     <= zhold_d;
            any_q       <= |eqz_d;
            all_q       <= &eqz_d;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                streak_q[c] <= streak_d[c];
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.eqz       = eqz_q;
    assign bus.ltz       = ltz_q;
    assign bus.gtz       = gtz_q;
    assign bus.zhold     = zhold_q;
    assign bus.any_eqz   = any_q;
    assign bus.all_eqz   = all_q;

`ifdef COMP_STICKY_EN
    logic [CHANNELS-1:0] sticky_q;

    // Sticky negative flags; a setting beat coinciding with clr leaves the bit set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= (bus.clr ? '0 : sticky_q) | (accept ? ltz_d : '0);
        end
    end

    assign bus.sticky_ltz = sticky_q;
`else
    assign bus.sticky_ltz = '0;
`endif

endmodule

// File: tb/tb_comp_flags_pipe.sv
// Self-checking bench for comp_flags_pipe: directed test-plan sequences followed
// by randomized traffic, all checked against a behavioural model. A second
// instance with STREAK_W=2 shares the stimulus to exercise counter saturation.
// Honours COMP_STICKY_EN in the model when the macro is defined.
module tb_comp_flags_pipe;
    localparam int W  = 32;
    localparam int CH = 4;
    localparam int TH = 3;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    comp_flags_pipe_if #(.WIDTH(W), .CHANNELS(CH)) bus ();
    comp_flags_pipe_if #(.WIDTH(W), .CHANNELS(CH)) bus2 ();

    comp_flags_pipe #(.WIDTH(W), .CHANNELS(CH), .STREAK_W(4), .THRESH(TH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    comp_flags_pipe #(.WIDTH(W), .CHANNELS(CH), .STREAK_W(2), .THRESH(TH)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
    );

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_data   = bus.in_data;
    assign bus2.out_ready = bus.out_ready;
    assign bus2.clr       = bus.clr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic          m_valid;
    logic [CH-1:0] m_eqz, m_ltz, m_gtz, m_zhold, m_zhold2, m_sticky;
    int            m_streak  [CH];
    int            m_streak2 [CH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_eqz    = '0;
        m_ltz    = '0;
        m_gtz    = '0;
        m_zhold  = '0;
        m_zhold2 = '0;
        m_sticky = '0;
        for (int c = 0; c < CH; c++) begin
            m_streak[c]  = 0;
            m_streak2[c] = 0;
        end
    endtask

    task automatic check_outputs();
        check("out_valid", bus.out_valid, m_valid);
        check("out_valid2", bus2.out_valid, m_valid);
        check("sticky_ltz", bus.sticky_ltz, m_sticky);
        if (m_valid) begin
            check("eqz", bus.eqz, m_eqz);
            check("ltz", bus.ltz, m_ltz);
            check("gtz", bus.gtz, m_gtz);
            check("zhold", bus.zhold, m_zhold);
            check("any_eqz", bus.any_eqz, (m_eqz != 0));
            check("all_eqz", bus.all_eqz, (m_eqz == {CH{1'b1}}));
            check("zhold_sw2", bus2.zhold, m_zhold2);
        end
    endtask

    // One clock cycle: drive at negedge, check in_ready, update model at posedge, check after
    task automatic step(input logic v, input logic r, input logic [CH*W-1:0] d, input logic c);
        logic          acc;
        logic          exp_ready;
        logic [CH-1:0] new_ltz;
        int            wv;
        @(negedge clk);
        bus.in_valid  = v;
        bus.out_ready = r;
        bus.in_data   = d;
        bus.clr       = c;
        #1;
        exp_ready = !m_valid || r;
        check("in_ready", bus.in_ready, exp_ready);
        acc = v && exp_ready;
        new_ltz = '0;
        @(posedge clk);
        if (acc) begin
            for (int ch = 0; ch < CH; ch++) begin
                wv = int'(d[ch*W +: W]);
                m_eqz[ch] = (wv == 0);
                m_ltz[ch] = (wv < 0);
                m_gtz[ch] = (wv > 0);
                new_ltz[ch] = (wv < 0);
                m_streak[ch]  = (wv == 0) ? ((m_streak[ch]  < 15) ? m_streak[ch]  + 1 : 15) : 0;
                m_streak2[ch] = (wv == 0) ? ((m_streak2[ch] < 3)  ? m_streak2[ch] + 1 : 3)  : 0;
                m_zhold[ch]  = (m_streak[ch]  >= TH);
                m_zhold2[ch] = (m_streak2[ch] >= TH);
            end
            m_valid = 1'b1;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
`ifdef COMP_STICKY_EN
        m_sticky = (c ? '0 : m_sticky) | new_ltz;
`endif
        #1;
        check_outputs();
    endtask

    function automatic logic [CH*W-1:0] pack4(input logic [W-1:0] w0, input logic [W-1:0] w1,
                                              input logic [W-1:0] w2, input logic [W-1:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 5))
            0, 1:    return '0;
            2:       return 32'h8000_0000;
            3:       return -W'($urandom_range(1, 100));
            4:       return W'($urandom_range(1, 100));
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic [CH*W-1:0] rand_beat();
        return pack4(rand_word(), rand_word(), rand_word(), rand_word());
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.clr      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_flags", {bus.eqz, bus.ltz, bus.gtz, bus.zhold}, '0);
        check("rst_any_all", {bus.any_eqz, bus.all_eqz}, 2'b00);
        check("rst_sticky", bus.sticky_ltz, '0);
        check("rst_zhold2", bus2.zhold, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_data   = '0;
        bus.clr       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_flags", {bus.eqz, bus.ltz, bus.gtz, bus.zhold, bus.any_eqz, bus.all_eqz}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // First beat: {0, -5, 7, most-negative}
        step(1'b1, 1'b1, pack4(32'd0, -32'sd5, 32'd7, 32'h8000_0000), 1'b0);
        check("tp_eqz", bus.eqz, 4'b0001);
        check("tp_ltz", bus.ltz, 4'b1010);
        check("tp_gtz", bus.gtz, 4'b0100);
        check("tp_any", bus.any_eqz, 1'b1);
        check("tp_all", bus.all_eqz, 1'b0);

        // Zero streak on ch0: three zeros then a one
        step(1'b1, 1'b1, pack4(32'd1, 32'd1, 32'd1, 32'd1), 1'b0);
        step(1'b1, 1'b1, pack4(32'd0, 32'd1, 32'd1, 32'd1), 1'b0);
        check("streak_z1", bus.zhold[0], 1'b0);
        step(1'b1, 1'b1, pack4(32'd0, 32'd1, 32'd1, 32'd1), 1'b0);
        check("streak_z2", bus.zhold[0], 1'b0);
        step(1'b1, 1'b1, pack4(32'd0, 32'd1, 32'd1, 32'd1), 1'b0);
        check("streak_z3", bus.zhold[0], 1'b1);
        step(1'b1, 1'b1, pack4(32'd1, 32'd1, 32'd1, 32'd1), 1'b0);
        check("streak_break", bus.zhold[0], 1'b0);

        // Five zero beats: the 2-bit counter saturates rather than wrapping
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, pack4(32'd0, 32'd0, 32'd0, 32'd0), 1'b0);
        end
        check("sat_all_eqz", bus.all_eqz, 1'b1);
        check("sat_zhold_sw2", bus2.zhold[0], 1'b1);

        // Stall: out_ready low for 4 cycles with changing input data
        step(1'b1, 1'b1, pack4(-32'sd9, 32'd0, 32'd3, 32'd0), 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, rand_beat(), 1'b0);
            check("stall_in_ready", bus.in_ready, 1'b0);
        end
        step(1'b1, 1'b1, pack4(32'd4, -32'sd4, 32'd0, 32'd4), 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);

        // Back-to-back beats
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, rand_beat(), 1'b0);
            check("b2b_valid", bus.out_valid, 1'b1);
        end

        // Reset mid-stream with valid output and nonzero streaks
        step(1'b1, 1'b1, pack4(32'd0, 32'd0, 32'd5, 32'd0), 1'b0);
        step(1'b1, 1'b0, pack4(32'd0, 32'd0, 32'd5, 32'd0), 1'b0);
        pulse_reset();
        step(1'b1, 1'b1, pack4(32'd0, 32'd0, 32'd0, 32'd0), 1'b0);
        step(1'b1, 1'b1, pack4(32'd0, 32'd0, 32'd0, 32'd0), 1'b0);
        check("restart_z2", bus.zhold, 4'b0000);
        step(1'b1, 1'b1, pack4(32'd0, 32'd0, 32'd0, 32'd0), 1'b0);
        check("restart_z3", bus.zhold, 4'b1111);

`ifdef COMP_STICKY_EN
        step(1'b1, 1'b1, pack4(32'd1, 32'd1, -32'sd1, 32'd1), 1'b0);
        check("sticky_set", bus.sticky_ltz[2], 1'b1);
        step(1'b1, 1'b1, pack4(32'd1, 32'd1, 32'd1, 32'd1), 1'b0);
        step(1'b1, 1'b1, pack4(32'd1, 32'd1, 32'd1, 32'd1), 1'b0);
        check("sticky_hold", bus.sticky_ltz[2], 1'b1);
        step(1'b1, 1'b1, pack4(32'd1, 32'd1, -32'sd3, 32'd1), 1'b1);
        check("sticky_set_wins", bus.sticky_ltz[2], 1'b1);
        step(1'b0, 1'b1, '0, 1'b1);
        check("sticky_clr", bus.sticky_ltz[2], 1'b0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 rand_beat(), ($urandom_range(0, 9) == 0));
            if (i == 1500) pulse_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
